// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with pc+imm target and 2-entry skid buffer
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [2:0]       ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [XLEN-1:0]  target_out,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int BW = 3 * XLEN + 1;

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic            dec_illegal;
    logic [BW-1:0]   in_bundle;
    logic [BW-1:0]   m_data;
    logic [BW-1:0]   k_data;
    logic            m_valid;
    logic            k_valid;
    logic            k_valid_nxt;
    logic            in_fire;
    logic            out_fire;
    logic            unused_opcode;

    // Opcode bits never feed an immediate field.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (ImmSrc)
            3'b000: dec_imm = XLEN'($signed(instr[31:20]));
            3'b001: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            3'b011: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            3'b100: dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            3'b101: dec_imm = XLEN'(instr[19:15]);
            3'b110: dec_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_target = pc_in + dec_imm;
    assign in_bundle  = {dec_illegal, pc_in, dec_target, dec_imm};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    // K only fills when M is stuck, and drains whenever M moves on.
    always_comb begin
        k_valid_nxt = k_valid;
        if (out_fire && k_valid)
            k_valid_nxt = in_fire;
        else if (!out_fire && m_valid && in_fire)
            k_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            k_valid     <= 1'b0;
            m_data      <= '0;
            k_data      <= '0;
            in_ready    <= 1'b1;
            illegal_cnt <= '0;
        end else begin
            k_valid  <= k_valid_nxt;
            in_ready <= !k_valid_nxt;
            if (out_fire) begin
                if (k_valid) begin
                    m_data  <= k_data;
                    m_valid <= 1'b1;
                    if (in_fire)
                        k_data <= in_bundle;
                end else begin
                    m_valid <= in_fire;
                    if (in_fire)
                        m_data <= in_bundle;
                end
            end else if (!m_valid) begin
                m_valid <= in_fire;
                if (in_fire)
                    m_data <= in_bundle;
            end else if (in_fire) begin
                k_data <= in_bundle;
            end
            if (in_fire && dec_illegal && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_valid   = m_valid;
    assign imm_out     = m_data[XLEN-1:0];
    assign target_out  = m_data[2*XLEN-1:XLEN];
    assign pc_out      = m_data[3*XLEN-1:2*XLEN];
    assign illegal_out = m_data[3*XLEN];

endmodule
